if_fetch_unit_n: RTL
====================

Name: if_fetch_unit_n

Overview:
- Parametrised N-lane instruction fetch unit for the superscalar core.
- Owns the fetch PC register and resolves redirects from the ME, EX and ID stages, with fixed priority ME > EX > ID.
- Issues one AHB-Lite single-word read per lane per bundle and tracks the data phase.
- Buffers returned bundles in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake.

Parameters:
- NLANES, 2, fetch width in instructions; legal values 1, 2, 4.
- DEPTH, 4, instruction-buffer depth in bundles; must be >= 2.
- RESET_PC, 32'h00000000, PC loaded on reset; must be 4-byte aligned.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- s_me_pcsrc / s_ex_pcsrc / s_id_pcsrc  in  1 each  redirect requests.
- s_me_bradd / s_ex_bradd / s_id_bradd  in  32 each  redirect targets.
- dec_ready  in  1  decode accepts the head bundle.
- dec_valid  out  1  head bundle valid.
- dec_pc  out  32  aligned base PC of the head bundle.
- dec_instr  out  32*NLANES  instruction words; lane i in bits [32i+31:32i].
- dec_mask  out  NLANES  per-lane valid flags.
- dec_fault  out  1  bus error on the bundle.
- ahb_HADDR  out  32*NLANES  per-lane address.
- ahb_HTRANS  out  2*NLANES  per-lane transfer type.
- ahb_HSIZE  out  3  constant 3'h2.
- ahb_HBURST  out  3  constant 3'h0.
- ahb_HPROT  out  4  constant 4'h3.
- ahb_HWRITE  out  1  constant 0.
- ahb_HMASTLOCK  out  1  constant 0.
- ahb_HRDATA  in  32*NLANES  per-lane read data.
- ahb_HREADY  in  1  combined ready from the interconnect.
- ahb_HRESP  in  1  combined error response.

Behaviour:
- Clock and reset: one clock (CLK); reset RST_N is synchronous, active-low.
- Reset state: pc=RESET_PC, FIFO count=0, no outstanding data phase, state RUN.
- Outputs while RST_N=0 and in the first cycle after release:
  - ahb_HTRANS all IDLE (2'h0), ahb_HADDR=0.
  - dec_valid=0, dec_mask=0, dec_fault=0, dec_pc=0, dec_instr=0.
- Bundle geometry:
  - base = pc with the low log2(NLANES*4) bits cleared; off = (pc-base)/4.
  - Lane i is valid when i >= off.
  - HADDR lane i = base+4i, driven on every lane.
  - HTRANS lane i = NONSEQ (2'h2) when issuing and lane i is valid, else IDLE.
- Redirect: redir = me|ex|id; target selected ME > EX > ID. In a redirect cycle:
  - No issue; all HTRANS IDLE.
  - At the edge: pc <= target, FIFO flushed (count=0), any outstanding data phase marked killed, state <= RUN.
- Issue condition: state RUN, !redir, and (count + outstanding + pending) < DEPTH.
  - pending = 1 when a bundle will be pushed this cycle.
  - This guarantees a push never overflows.
- Address acceptance: when issuing and HREADY=1.
  - pc <= base + 4*NLANES; the aligned base wraps modulo 2^32.
  - Data phase opens, recording base, mask and a kill flag cleared to 0.
  - HREADY=0: address phase holds, with HADDR/HTRANS stable.
- Data phase completes when HREADY=1.
  - If not killed: push {base, HRDATA, mask, fault=HRESP}.
  - Killed data is dropped.
  - Back-to-back issue is allowed: a new address is accepted in the same cycle the previous data completes.
- States:
  - RUN: normal operation.
  - HALT: entered when a fault bundle is pushed. No issue in HALT; leave only on redirect (to RUN).
  - The FIFO still drains in HALT.
- Decode side:
  - dec_valid = (count != 0); head fields are stable while dec_valid & !dec_ready.
  - Pop on dec_valid & dec_ready.
  - Simultaneous push and pop leaves count unchanged, including at count=DEPTH-1 with room reserved.
  - A redirect in the same cycle as a pop or push: the flush wins, count=0.
- Latency: redirect in cycle t (HREADY=1 throughout):
  - Address phase in t+1, data captured at the end of t+2.
  - dec_valid=1 in t+3.
  - Throughput: one bundle per cycle when dec_ready=1.
- Reset mid-transaction: the outstanding data phase is abandoned and FIFO contents discarded; the bus must tolerate the dropped data.

Test Plan:
- Reset release with NLANES=2, RESET_PC=0, HREADY=1, dec_ready=1, HRDATA={32'hB,32'hA} -> HADDR lanes 0x0/0x4 NONSEQ in cycle 1; dec_valid=1, dec_pc=0x0, dec_instr={B,A}, dec_mask=2'b11 in cycle 3; then pc steps 0x8, 0x10, … one bundle per cycle.
- Redirect s_id_bradd=0x104 alone -> lane0 HTRANS IDLE, lane1 HADDR=0x104 NONSEQ; delivered bundle has dec_pc=0x100, dec_mask=2'b10. Same cycle with s_me_pcsrc=1 and s_me_bradd=0x200 -> ME wins; HADDR lane0=0x200.
- dec_ready=0 with DEPTH=4 -> exactly 4 bundles stored, HTRANS IDLE afterwards; one pop -> exactly one further issue.
- Redirect asserted during an outstanding data phase, with HREADY low for 2 cycles -> the stale data is not pushed; the first dec_pc equals the redirect target's aligned base.
- HRESP=1 on bundle at 0x40 -> bundle delivered with dec_fault=1, no further HTRANS NONSEQ; redirect to 0x80 -> fetch resumes at 0x80.
- RST_N=0 for one cycle mid-stream with count=3 -> dec_valid=0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_n.sv
// if_fetch_unit_n: N-lane AHB-Lite instruction fetch, redirect resolution (ME > EX > ID) and bundle buffer.
// Latency: redirect (or reset release) in cycle t -> address phase t+1, data t+2, dec_valid t+3.
// Backpressure: dec_ready low fills the DEPTH-entry buffer; issue stops once buffered + in-flight bundles reach DEPTH.

module if_fetch_unit_n #(
  parameter int          NLANES   = 2,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   s_me_pcsrc,
  input  logic                   s_ex_pcsrc,
  input  logic                   s_id_pcsrc,
  input  logic [31:0]            s_me_bradd,
  input  logic [31:0]            s_ex_bradd,
  input  logic [31:0]            s_id_bradd,
  input  logic                   dec_ready,
  output logic                   dec_valid,
  output logic [31:0]            dec_pc,
  output logic [32*NLANES-1:0]   dec_instr,
  output logic [NLANES-1:0]      dec_mask,
  output logic                   dec_fault,
  output logic [32*NLANES-1:0]   ahb_HADDR,
  output logic [2*NLANES-1:0]    ahb_HTRANS,
  output logic [2:0]             ahb_HSIZE,
  output logic [2:0]             ahb_HBURST,
  output logic [3:0]             ahb_HPROT,
  output logic                   ahb_HWRITE,
  output logic                   ahb_HMASTLOCK,
  input  logic [32*NLANES-1:0]   ahb_HRDATA,
  input  logic                   ahb_HREADY,
  input  logic                   ahb_HRESP
);

  localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] BMASK = 32'(NLANES * 4 - 1);
  localparam logic [31:0] BSTEP = 32'(NLANES * 4);
  localparam logic [1:0]  HT_IDLE   = 2'h0;
  localparam logic [1:0]  HT_NONSEQ = 2'h2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Architectural state
  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  started_q, started_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

  // Open AHB data phase
  logic                  dp_vld_q, dp_vld_d;
  logic [31:0]           dp_base_q, dp_base_d;
  logic [NLANES-1:0]     dp_mask_q, dp_mask_d;
  logic                  dp_kill_q, dp_kill_d;

  // Bundle buffer storage
  logic [31:0]           mem_base_q  [DEPTH];
  logic [31:0]           mem_base_d  [DEPTH];
  logic [32*NLANES-1:0]  mem_instr_q [DEPTH];
  logic [32*NLANES-1:0]  mem_instr_d [DEPTH];
  logic [NLANES-1:0]     mem_mask_q  [DEPTH];
  logic [NLANES-1:0]     mem_mask_d  [DEPTH];
  logic                  mem_fault_q [DEPTH];
  logic                  mem_fault_d [DEPTH];

  // Combinational control
  logic                  redir;
  logic [31:0]           redir_tgt;
  logic [31:0]           base;
  logic [31:0]           off;
  logic [NLANES-1:0]     lane_mask;
  logic                  push;
  logic                  pop;
  logic                  buf_vld;
  logic [31:0]           occ;
  logic                  issue;
  logic                  accept;
  logic                  addr_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Redirect resolution: ME beats EX beats ID
  always_comb begin
    redir     = s_me_pcsrc | s_ex_pcsrc | s_id_pcsrc;
    redir_tgt = s_id_bradd;
    if (s_me_pcsrc) begin
      redir_tgt = s_me_bradd;
    end else if (s_ex_pcsrc) begin
      redir_tgt = s_ex_bradd;
    end
  end

  // Bundle geometry: aligned base and lanes at or above the PC's lane offset
  always_comb begin
    base      = pc_q & ~BMASK;
    off       = (pc_q - base) >> 2;
    lane_mask = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane_mask[i] = (32'(i) >= off);
    end
  end

  // Issue/push/pop decisions; occupancy counts buffered, in-flight and about-to-land bundles
  always_comb begin
    buf_vld = (count_q != '0);
    pop     = buf_vld & dec_ready;
    push    = dp_vld_q & ahb_HREADY & ~dp_kill_q & ~redir;
    occ     = 32'(count_q) + 32'(dp_vld_q) + 32'(push);
    addr_en = RST_N & started_q;
    issue   = addr_en & (state_q == ST_RUN) & ~redir & (occ < 32'(DEPTH));
    accept  = issue & ahb_HREADY;
  end

  // FSM next state: a pushed fault halts fetch until the next redirect
  always_comb begin
    state_d = state_q;
    if (redir) begin
      state_d = ST_RUN;
    end else if (push && ahb_HRESP) begin
      state_d = ST_HALT;
    end
  end

  // PC and data-phase tracking
  always_comb begin
    pc_d      = pc_q;
    started_d = 1'b1;
    dp_vld_d  = dp_vld_q;
    dp_base_d = dp_base_q;
    dp_mask_d = dp_mask_q;
    dp_kill_d = dp_kill_q;
    if (dp_vld_q && ahb_HREADY) begin
      dp_vld_d = 1'b0;
    end
    if (accept) begin
      pc_d      = base + BSTEP;
      dp_vld_d  = 1'b1;
      dp_base_d = base;
      dp_mask_d = lane_mask;
      dp_kill_d = 1'b0;
    end
    if (redir) begin
      pc_d      = redir_tgt;
      dp_kill_d = 1'b1;
    end
  end

  // Bundle buffer pointers, count and storage; a redirect flush overrides push/pop
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_base_d  = mem_base_q;
    mem_instr_d = mem_instr_q;
    mem_mask_d  = mem_mask_q;
    mem_fault_d = mem_fault_q;
    if (push) begin
      mem_base_d[wr_ptr_q]  = dp_base_q;
      mem_instr_d[wr_ptr_q] = ahb_HRDATA;
      mem_mask_d[wr_ptr_q]  = dp_mask_q;
      mem_fault_d[wr_ptr_q] = ahb_HRESP;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (redir) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dp_vld_q  <= 1'b0;
      dp_base_q <= '0;
      dp_mask_q <= '0;
      dp_kill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      started_q <= started_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      dp_vld_q  <= dp_vld_d;
      dp_base_q <= dp_base_d;
      dp_mask_q <= dp_mask_d;
      dp_kill_q <= dp_kill_d;
    end
  end

  // Buffer storage needs no reset: entries are only visible while counted
  always_ff @(posedge CLK) begin
    mem_base_q  <= mem_base_d;
    mem_instr_q <= mem_instr_d;
    mem_mask_q  <= mem_mask_d;
    mem_fault_q <= mem_fault_d;
  end

  // AHB address phase: every lane carries its address, only valid lanes request
  always_comb begin
    ahb_HADDR     = '0;
    ahb_HTRANS    = '0;
    ahb_HSIZE     = 3'h2;
    ahb_HBURST    = 3'h0;
    ahb_HPROT     = 4'h3;
    ahb_HWRITE    = 1'b0;
    ahb_HMASTLOCK = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      ahb_HADDR[32*i +: 32] = addr_en ? (base + 32'(4 * i)) : 32'h0;
      ahb_HTRANS[2*i +: 2]  = (issue && lane_mask[i]) ? HT_NONSEQ : HT_IDLE;
    end
  end

  // Decode head: fields forced to zero whenever no bundle is presented
  always_comb begin
    dec_valid = RST_N & buf_vld;
    dec_pc    = '0;
    dec_instr = '0;
    dec_mask  = '0;
    dec_fault = 1'b0;
    if (dec_valid) begin
      dec_pc    = mem_base_q[rd_ptr_q];
      dec_instr = mem_instr_q[rd_ptr_q];
      dec_mask  = mem_mask_q[rd_ptr_q];
      dec_fault = mem_fault_q[rd_ptr_q];
    end
  end

endmodule
